// File: rtl/mod_exp_pkg.sv
// Shared types for the modular exponentiation controller and its multiplier sequencer.
package mod_exp_pkg;

    typedef enum logic [2:0] {
        StIdle, StPre, StScan, StSqr, StMul, StConv, StOut
    } state_e;

    typedef enum logic [2:0] {
        SubIdle, SubIssue, SubOpA, SubOpB, SubCollect
    } sub_state_e;

    localparam logic [1:0] SelC = 2'd0;
    localparam logic [1:0] SelR = 2'd1;
    localparam logic [1:0] SelT = 2'd2;
    localparam logic [1:0] SelD = 2'd3;

endpackage

// File: rtl/mod_exp_stream_if.sv
// Host load/result port plus the start/stream link to the Montgomery multiplier.
interface mod_exp_stream_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic [1:0]   in_sel;
    logic [W-1:0] in_data;
    logic         start;
    logic         busy;
    logic         err;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         done;
    logic         mp_start;
    logic         mp_in_valid;
    logic [W-1:0] mp_in_data;
    logic         mp_out_valid;
    logic [W-1:0] mp_out_data;

    modport slave (
        input  in_valid, in_sel, in_data, start, mp_out_valid, mp_out_data,
        output busy, err, out_valid, out_data, done, mp_start, mp_in_valid, mp_in_data
    );

    modport master (
        output in_valid, in_sel, in_data, start, mp_out_valid, mp_out_data,
        input  busy, err, out_valid, out_data, done, mp_start, mp_in_valid, mp_in_data
    );
endinterface

// File: rtl/mp_op_sequencer.sv
// Runs one multiplier operation: start pulse, NW A words, NW B words, then NW result captures.
module mp_op_sequencer
    import mod_exp_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned NW = 128,
    parameter int unsigned CW = $clog2(NW) + 1,
    parameter int unsigned IW = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go_i,
    input  logic [W-1:0]  a_word_i,
    input  logic [W-1:0]  b_word_i,
    input  logic          mp_out_valid_i,
    output logic          idle_o,
    output logic [IW-1:0] idx_o,
    output logic          mp_start_o,
    output logic          mp_in_valid_o,
    output logic [W-1:0]  mp_in_data_o,
    output logic          cap_o,
    output logic          op_done_o
);
    localparam logic [CW-1:0] Last = CW'(NW - 1);

    sub_state_e    sub_q, sub_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_q <= SubIdle;
            cnt_q <= '0;
        end else begin
            sub_q <= sub_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        sub_d         = sub_q;
        cnt_d         = cnt_q;
        mp_start_o    = 1'b0;
        mp_in_valid_o = 1'b0;
        mp_in_data_o  = '0;
        cap_o         = 1'b0;
        op_done_o     = 1'b0;
        unique case (sub_q)
            SubIdle: if (go_i) sub_d = SubIssue;
            SubIssue: begin
                mp_start_o = 1'b1;
                cnt_d      = '0;
                sub_d      = SubOpA;
            end
            SubOpA: begin
                mp_in_valid_o = 1'b1;
                mp_in_data_o  = a_word_i;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == Last) begin
                    cnt_d = '0;
                    sub_d = SubOpB;
                end
            end
            SubOpB: begin
                mp_in_valid_o = 1'b1;
                mp_in_data_o  = b_word_i;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == Last) begin
                    cnt_d = '0;
                    sub_d = SubCollect;
                end
            end
            SubCollect: begin
                if (mp_out_valid_i) begin
                    cap_o = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == Last) begin
                        cnt_d     = '0;
                        op_done_o = 1'b1;
                        sub_d     = SubIdle;
                    end
                end
            end
            default: sub_d = SubIdle;
        endcase
    end

    assign idle_o = (sub_q == SubIdle);
    assign idx_o  = cnt_q[IW-1:0];

endmodule

// File: rtl/mod_exp_stream.sv
// Left-to-right square-and-multiply c^d mod n controller driving a word-serial Montgomery core.
module mod_exp_stream
    import mod_exp_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned NW = 128,
    parameter int unsigned CW = $clog2(NW) + 1
) (
    input logic              clk,
    input logic              reset,
    mod_exp_stream_if.slave  bus
);
    localparam int unsigned   IW   = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned   KW   = $clog2(W * NW);
    localparam logic [CW-1:0] Last = CW'(NW - 1);
    localparam logic [KW-1:0] KTop = KW'(W * NW - 1);

    typedef logic [NW-1:0][W-1:0] operand_t;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [3:0]          loaded_q, loaded_d;
    logic [3:0][CW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]       ocnt_q, ocnt_d;
    logic                err_q, err_d, done_q, done_d;
    operand_t            c_q, r_q, t_q, d_q, cb_q, mb_q;
    logic [W*NW-1:0]     d_bits;
    logic                load_en, accept, go;
    logic [IW-1:0]       widx, seq_idx;
    logic [W-1:0]        a_word, b_word;
    logic                seq_idle, cap, op_done;

    assign d_bits = d_q;
    assign widx   = ptr_q[bus.in_sel][IW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            loaded_q <= '0;
            ptr_q    <= '0;
            ocnt_q   <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            loaded_q <= loaded_d;
            ptr_q    <= ptr_d;
            ocnt_q   <= ocnt_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // Operand storage carries no reset; validity is tracked by loaded_q.
    always_ff @(posedge clk) begin
        if (load_en) begin
            unique case (bus.in_sel)
                SelC: c_q[widx] <= bus.in_data;
                SelR: r_q[widx] <= bus.in_data;
                SelT: t_q[widx] <= bus.in_data;
                SelD: d_q[widx] <= bus.in_data;
            endcase
        end
        if (accept) begin
            mb_q <= r_q;
        end else if (cap && state_q == StPre) begin
            cb_q[seq_idx] <= bus.mp_out_data;
        end else if (cap) begin
            mb_q[seq_idx] <= bus.mp_out_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        loaded_d = loaded_q;
        ptr_d    = ptr_q;
        ocnt_d   = ocnt_q;
        err_d    = 1'b0;
        done_d   = 1'b0;
        load_en  = 1'b0;
        accept   = 1'b0;
        go       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    load_en = 1'b1;
                    if (ptr_q[bus.in_sel] == Last) begin
                        ptr_d[bus.in_sel]    = '0;
                        loaded_d[bus.in_sel] = 1'b1;
                    end else begin
                        ptr_d[bus.in_sel] = ptr_q[bus.in_sel] + 1'b1;
                    end
                end
                if (bus.start) begin
                    if (&loaded_q) begin
                        accept  = 1'b1;
                        k_d     = KTop;
                        state_d = StPre;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StPre: begin
                go = seq_idle;
                if (op_done) state_d = StScan;
            end
            StScan: begin
                if (d_bits[k_q]) state_d = StSqr;
                else if (k_q == '0) state_d = StConv;
                else k_d = k_q - 1'b1;
            end
            StSqr: begin
                go = seq_idle;
                if (op_done) begin
                    if (d_bits[k_q]) state_d = StMul;
                    else if (k_q == '0) state_d = StConv;
                    else k_d = k_q - 1'b1;
                end
            end
            StMul: begin
                go = seq_idle;
                if (op_done) begin
                    if (k_q == '0) begin
                        state_d = StConv;
                    end else begin
                        k_d     = k_q - 1'b1;
                        state_d = StSqr;
                    end
                end
            end
            StConv: begin
                go = seq_idle;
                if (op_done) begin
                    ocnt_d  = '0;
                    state_d = StOut;
                end
            end
            StOut: begin
                ocnt_d = ocnt_q + 1'b1;
                if (ocnt_q == Last) begin
                    ocnt_d  = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        a_word = mb_q[seq_idx];
        b_word = mb_q[seq_idx];
        unique case (state_q)
            StPre: begin
                a_word = c_q[seq_idx];
                b_word = t_q[seq_idx];
            end
            StMul:   b_word = cb_q[seq_idx];
            StConv:  b_word = (seq_idx == '0) ? W'(1) : '0;
            default: ;
        endcase
    end

    mp_op_sequencer #(
        .W  (W),
        .NW (NW),
        .CW (CW),
        .IW (IW)
    ) u_seq (
        .clk            (clk),
        .reset          (reset),
        .go_i           (go),
        .a_word_i       (a_word),
        .b_word_i       (b_word),
        .mp_out_valid_i (bus.mp_out_valid),
        .idle_o         (seq_idle),
        .idx_o          (seq_idx),
        .mp_start_o     (bus.mp_start),
        .mp_in_valid_o  (bus.mp_in_valid),
        .mp_in_data_o   (bus.mp_in_data),
        .cap_o          (cap),
        .op_done_o      (op_done)
    );

    assign bus.busy      = (state_q != StIdle);
    assign bus.err       = err_q;
    assign bus.done      = done_q;
    assign bus.out_valid = (state_q == StOut);
    assign bus.out_data  = (state_q == StOut) ? mb_q[ocnt_q[IW-1:0]] : '0;

endmodule

// File: tb/tb_mod_exp_stream.sv
// Bench for mod_exp_stream: W=8, NW=2, n=241, behavioural Montgomery multiplier with R=2^16.
module tb_mod_exp_stream;
    import mod_exp_pkg::*;

    localparam int unsigned     W  = 8;
    localparam int unsigned     NW = 2;
    localparam longint unsigned N  = 241;
    localparam longint unsigned R  = 65536;

    typedef struct {
        longint unsigned c;
        longint unsigned d;
        longint unsigned res;
        int              starts;
        int              gap;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   gap_max = 0;
    int   mp_starts = 0;
    longint unsigned r_val, t_val, r_inv;

    mod_exp_stream_if #(.W(W)) ifc ();

    mod_exp_stream #(.W(W), .NW(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned monpro(input longint unsigned a, input longint unsigned b);
        return ((a * b) % N) * r_inv % N;
    endfunction

    function automatic longint unsigned mod_pow(input longint unsigned b, input longint unsigned e);
        longint unsigned acc  = 1;
        longint unsigned base = b % N;
        longint unsigned x    = e;
        while (x != 0) begin
            if ((x & 1) != 0) acc = (acc * base) % N;
            base = (base * base) % N;
            x = x >> 1;
        end
        return acc;
    endfunction

    function automatic int op_count(input longint unsigned e);
        int bl = 0;
        int pc = 0;
        if (e == 0) return 2;
        for (int i = 0; i < 64; i++) begin
            if (((e >> i) & 1) != 0) begin
                pc++;
                bl = i + 1;
            end
        end
        return 2 + bl + pc;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [1:0] sel, input logic [W-1:0] data);
        ifc.in_valid = 1'b1;
        ifc.in_sel   = sel;
        ifc.in_data  = data;
        cyc();
        ifc.in_valid = 1'b0;
    endtask

    task automatic load_op(input logic [1:0] sel, input longint unsigned v);
        for (int i = 0; i < NW; i++) load_word(sel, W'(v >> (W * i)));
    endtask

    task automatic check_quiet(input string name);
        check({name, ".busy"}, ifc.busy, 0);
        check({name, ".err"}, ifc.err, 0);
        check({name, ".out_valid"}, ifc.out_valid, 0);
        check({name, ".out_data"}, ifc.out_data, 0);
        check({name, ".done"}, ifc.done, 0);
        check({name, ".mp_start"}, ifc.mp_start, 0);
        check({name, ".mp_in_valid"}, ifc.mp_in_valid, 0);
        check({name, ".mp_in_data"}, ifc.mp_in_data, 0);
    endtask

    task automatic run_exp(input string name, input longint unsigned exp_res, input int exp_starts,
                           input bit toggle);
        logic [W*NW-1:0] got = '0;
        int outs = 0;
        int last_out = -10;
        int done_cyc = -1;
        int errs = 0;
        int n = 0;
        mp_starts = 0;
        ifc.start = 1'b1;
        cyc();
        ifc.start = 1'b0;
        check({name, ".busy_after_start"}, ifc.busy, 1);
        while (done_cyc < 0 && n < 5000) begin
            if (toggle) begin
                ifc.in_valid = 1'($urandom_range(1, 0));
                ifc.in_sel   = 2'($urandom_range(3, 0));
                ifc.in_data  = W'($urandom);
                ifc.start    = 1'($urandom_range(1, 0));
            end
            cyc();
            n++;
            if (ifc.err) errs++;
            if (ifc.out_valid) begin
                if (outs < NW) got[outs*W +: W] = ifc.out_data;
                outs++;
                last_out = n;
            end
            if (ifc.done) done_cyc = n;
        end
        ifc.in_valid = 1'b0;
        ifc.start    = 1'b0;
        check({name, ".done_seen"}, done_cyc >= 0, 1);
        check({name, ".result"}, got, exp_res);
        check({name, ".out_words"}, outs, NW);
        check({name, ".done_gap"}, done_cyc - last_out, 1);
        check({name, ".busy_at_done"}, ifc.busy, 0);
        check({name, ".mp_starts"}, mp_starts, exp_starts);
        check({name, ".err_while_busy"}, errs, 0);
        cyc();
        check({name, ".done_pulse"}, ifc.done, 0);
    endtask

    // Behavioural multiplier: gathers A then B, answers with MonPro words after random gaps.
    initial begin : mp_model
        int phase = 0;
        int cnt = 0;
        int gap = 0;
        longint unsigned a_v = 0;
        longint unsigned b_v = 0;
        longint unsigned res_v = 0;
        ifc.mp_out_valid = 1'b0;
        ifc.mp_out_data  = '0;
        forever begin
            cyc();
            if (reset) begin
                phase = 0;
                ifc.mp_out_valid = 1'b0;
                ifc.mp_out_data  = '0;
            end else begin
                case (phase)
                    0: if (ifc.mp_start) begin
                        mp_starts++;
                        phase = 1;
                        cnt = 0;
                        a_v = 0;
                        b_v = 0;
                    end
                    1: if (ifc.mp_in_valid) begin
                        if (cnt < NW) a_v = a_v | (64'(ifc.mp_in_data) << (W * cnt));
                        else b_v = b_v | (64'(ifc.mp_in_data) << (W * (cnt - NW)));
                        cnt++;
                        if (cnt == 2 * NW) begin
                            res_v = monpro(a_v, b_v);
                            phase = 2;
                            cnt = 0;
                            gap = int'($urandom_range(gap_max, 0));
                        end
                    end
                    2: begin
                        if (cnt == NW) begin
                            ifc.mp_out_valid = 1'b0;
                            ifc.mp_out_data  = '0;
                            phase = 0;
                        end else if (gap > 0) begin
                            ifc.mp_out_valid = 1'b0;
                            gap--;
                        end else begin
                            ifc.mp_out_valid = 1'b1;
                            ifc.mp_out_data  = W'(res_v >> (W * cnt));
                            cnt++;
                            gap = int'($urandom_range(gap_max, 0));
                        end
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    initial begin : main
        vec_t vecs[3];
        int   seen;
        int   n;
        r_inv = 0;
        for (longint unsigned x = 1; x < N; x++) if (((R * x) % N) == 1) r_inv = x;
        r_val = R % N;
        t_val = (R * R) % N;
        vecs[0] = '{c: 2,   d: 5, res: 64'h20, starts: 7, gap: 0};
        vecs[1] = '{c: 2,   d: 0, res: 64'h01, starts: 2, gap: 1};
        vecs[2] = '{c: 300, d: 1, res: 64'h3B, starts: 4, gap: 2};

        ifc.in_valid = 1'b0;
        ifc.in_sel   = '0;
        ifc.in_data  = '0;
        ifc.start    = 1'b0;
        cyc();
        check_quiet("reset_held");
        cyc();
        reset = 1'b0;
        cyc();
        check_quiet("reset_released");

        // Start refused until d is loaded.
        load_op(SelC, 2);
        load_op(SelR, r_val);
        load_op(SelT, t_val);
        ifc.start = 1'b1;
        cyc();
        ifc.start = 1'b0;
        check("s4.err", ifc.err, 1);
        check("s4.busy", ifc.busy, 0);
        cyc();
        check("s4.err_pulse", ifc.err, 0);
        load_op(SelD, 5);
        run_exp("s4.run", 64'h20, 7, 1'b0);

        for (int i = 0; i < 3; i++) begin
            gap_max = vecs[i].gap;
            load_op(SelC, vecs[i].c);
            load_op(SelD, vecs[i].d);
            run_exp($sformatf("vec%0d", i), vecs[i].res, vecs[i].starts, 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            longint unsigned cv;
            longint unsigned dv;
            cv = longint'($urandom_range(65535, 0));
            dv = (i < 2) ? longint'($urandom_range(15, 0)) : longint'($urandom_range(65535, 0));
            gap_max = 3;
            load_op(SelC, cv);
            load_op(SelD, dv);
            run_exp($sformatf("rand%0d", i), mod_pow(cv, dv), op_count(dv), 1'b0);
        end

        // Gapped multiplier output with host noise while busy.
        gap_max = 3;
        load_op(SelC, 2);
        load_op(SelD, 5);
        run_exp("s6", 64'h20, 7, 1'b1);

        // Reset during the first squaring, then a start without reload.
        gap_max = 0;
        load_op(SelC, 2);
        load_op(SelD, 5);
        ifc.start = 1'b1;
        cyc();
        ifc.start = 1'b0;
        seen = 0;
        n = 0;
        while (seen < 2 && n < 2000) begin
            cyc();
            n++;
            if (ifc.mp_start) seen++;
        end
        check("s5.reached_sqr", seen, 2);
        reset = 1'b1;
        #1;
        check_quiet("s5.in_reset");
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        ifc.start = 1'b1;
        cyc();
        ifc.start = 1'b0;
        check("s5.err", ifc.err, 1);
        check("s5.busy", ifc.busy, 0);
        cyc();
        check("s5.err_pulse", ifc.err, 0);
        check("s5.busy_after", ifc.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
